r200_mem_arb: RTL and testbench
===============================

// Module: r200_mem_arb
// PURPOSE
//  Arbiter and sequencer sharing one external memory port between instruction fetch (IF) and
//  data access (DM) of the r200 5-stage pipeline. One outstanding transaction at a time.
//  Data requests have priority, with an anti-starvation limit for fetch. Fetch responses can
//  be killed on a branch/jump redirect. Sits between r200if/r200mem and the memory/bus.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width; byte enables are DW/8 bits wide
//  STARVE_MAX  4   max consecutive DM grants while if_req is pending (>=1)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  if_req     in   1      fetch request; held with if_addr until if_gnt
//  if_addr    in   AW     fetch address
//  if_kill    in   1      redirect: discard pending or in-flight fetch
//  if_gnt     out  1      fetch accepted this cycle
//  if_rvalid  out  1      1-cycle pulse, if_rdata valid
//  if_rdata   out  DW     fetched instruction
//  dm_req     in   1      data request; held with dm_* until dm_gnt
//  dm_we      in   1      1 = write, 0 = read
//  dm_addr    in   AW     data address
//  dm_wdata   in   DW     write data
//  dm_be      in   DW/8   byte enables (writes)
//  dm_gnt     out  1      data request accepted this cycle
//  dm_rvalid  out  1      1-cycle pulse: read data valid / write done
//  dm_rdata   out  DW     read data
//  m_req      out  1      memory request; held until m_ack
//  m_we, m_addr, m_wdata, m_be  out  1/AW/DW/DW/8  registered copy of the granted request
//  m_ack      in   1      memory accepted the request
//  m_rvalid   in   1      completion (reads and writes), 1-cycle pulse
//  m_rdata    in   DW     read data, valid with m_rvalid
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, all outputs 0, starve_cnt=0, owner=IF, drop=0,
//    m_* registers 0. Reset mid-transaction abandons it; m_req falls immediately.
//  - FSM states:
//    - IDLE: arbitrate. Grant is combinational. Winner's request is captured into m_* regs
//      and owner. Go to ISSUE. If no request is granted, stay in IDLE.
//    - ISSUE: m_req=1. Stay until m_ack=1, then go to WAIT.
//    - WAIT: stay until m_rvalid=1. Then capture m_rdata into owner's rdata reg (reads only)
//      and go to RESP.
//    - RESP: pulse owner's rvalid (IF pulse suppressed if drop=1). Clear drop. Go to IDLE.
//  - Arbitration in IDLE:
//    - if_req is eligible only when if_kill=0.
//    - DM wins if dm_req=1, unless if_req is eligible and starve_cnt==STARVE_MAX; then IF wins.
//    - Exactly one gnt per cycle, and only in IDLE.
//  - starve_cnt:
//    - +1 on a DM grant while IF is eligible, saturating at STARVE_MAX.
//    - Cleared on an IF grant, or on a DM grant with if_req=0.
//  - Kill:
//    - if_kill=1 while owner=IF and state is ISSUE, WAIT or RESP sets drop=1.
//    - The bus transaction still completes: m_req is never withdrawn before m_ack.
//  - if_rdata/dm_rdata hold their last read value. Writes do not change dm_rdata.
//  - m_rvalid outside WAIT is ignored. m_ack outside ISSUE is ignored.
//  - Minimum latency: gnt (cycle 0), m_req+m_ack (cycle 1), m_rvalid (cycle 2),
//    rvalid (cycle 3). Back-to-back grants every 4 cycles at best.
// TESTING
//  1. Reset mid-WAIT (rst low 1 cycle) -> busy=0, m_req=0, no rvalid; a later m_rvalid is ignored.
//  2. if_req, addr 0x100; m_ack same cycle; m_rvalid next cycle with m_rdata=0x00500093
//     -> if_gnt@0, if_rvalid@3, if_rdata=0x00500093.
//  3. if_req and dm_req (read 0x2000) in the same cycle -> dm_gnt first. if_gnt on the next
//     IDLE cycle, if dm_req drops.
//  4. dm_req held high, if_req high, STARVE_MAX=4 -> 4 dm_gnt, then if_gnt,
//     then starve_cnt=0.
//  5. IF read in WAIT, if_kill pulse -> transaction completes, if_rvalid stays 0, if_rdata
//     unchanged. Next fetch returns normally.
//  6. DM write 0xDEADBEEF, be=4'b0011, m_ack delayed 3 cycles -> m_req/m_addr/m_be stable
//     for 4 cycles. dm_rvalid pulses after m_rvalid. dm_rdata unchanged.

Source files
------------

// File: rtl/r200_mem_arb.sv
// r200 memory arbiter: shares one external memory port between instruction fetch and data access.
// Data requests win by default. Fetch is bounded to STARVE_MAX lost grants, and redirects drop stale fetch data.
module r200_mem_arb #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_kill,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    input  logic [DW/8-1:0] dm_be,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [DW-1:0]   dm_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_be,
    input  logic            m_ack,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output logic            busy
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              drop_q, drop_d;
    logic [CW-1:0]     starve_cnt_q, starve_cnt_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [AW-1:0]     m_addr_q, m_addr_d;
    logic [DW-1:0]     m_wdata_q, m_wdata_d;
    logic [DW/8-1:0]   m_be_q, m_be_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              dm_rvalid_q, dm_rvalid_d;
    logic [DW-1:0]     if_rdata_q, if_rdata_d;
    logic [DW-1:0]     dm_rdata_q, dm_rdata_d;
    logic              busy_q, busy_d;

    logic if_elig, starve_hit, dm_win, if_win;

    always_comb begin
        if_elig    = if_req && !if_kill;
        starve_hit = if_elig && (starve_cnt_q == STARVE_LIM);
        dm_win     = (state_q == IDLE) && dm_req && !starve_hit;
        if_win     = (state_q == IDLE) && if_elig && !dm_win;
    end

    // owner_q: 0 = fetch, 1 = data
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_be_d       = m_be_q;
        if_rvalid_d  = 1'b0;
        dm_rvalid_d  = 1'b0;
        if_rdata_d   = if_rdata_q;
        dm_rdata_d   = dm_rdata_q;
        drop_d       = drop_q | (if_kill && !owner_q && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (dm_win) begin
                    state_d   = ISSUE;
                    owner_d   = 1'b1;
                    m_req_d   = 1'b1;
                    m_we_d    = dm_we;
                    m_addr_d  = dm_addr;
                    m_wdata_d = dm_wdata;
                    m_be_d    = dm_be;
                    if (if_elig) begin
                        if (starve_cnt_q != STARVE_LIM) starve_cnt_d = starve_cnt_q + 1'b1;
                    end else if (!if_req) begin
                        starve_cnt_d = '0;
                    end
                end else if (if_win) begin
                    state_d      = ISSUE;
                    owner_d      = 1'b0;
                    m_req_d      = 1'b1;
                    m_we_d       = 1'b0;
                    m_addr_d     = if_addr;
                    m_wdata_d    = '0;
                    m_be_d       = '0;
                    starve_cnt_d = '0;
                end
            end
            ISSUE: begin
                if (m_ack) begin
                    state_d = WAIT;
                    m_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (m_rvalid) begin
                    state_d = RESP;
                    if (owner_q) begin
                        dm_rvalid_d = 1'b1;
                        if (!m_we_q) dm_rdata_d = m_rdata;
                    end else if (!drop_d) begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = m_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                drop_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            drop_q       <= 1'b0;
            starve_cnt_q <= '0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_be_q       <= '0;
            if_rvalid_q  <= 1'b0;
            dm_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            drop_q       <= drop_d;
            starve_cnt_q <= starve_cnt_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_be_q       <= m_be_d;
            if_rvalid_q  <= if_rvalid_d;
            dm_rvalid_q  <= dm_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            dm_rdata_q   <= dm_rdata_d;
            busy_q       <= busy_d;
        end
    end

    // Grants are combinational, so they are forced low while reset is held.
    assign if_gnt    = if_win & rst;
    assign dm_gnt    = dm_win & rst;
    assign if_rvalid = if_rvalid_q;
    assign dm_rvalid = dm_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_be      = m_be_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_r200_mem_arb.sv
// Directed bench for r200_mem_arb. Read data is pushed to per-port queues when the memory side returns it.
// Entries are popped and compared when the arbiter pulses rvalid.
module tb_r200_mem_arb;

   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk;
   logic            rst;
   logic            if_req;
   logic [AW-1:0]   if_addr;
   logic            if_kill;
   logic            if_gnt;
   logic            if_rvalid;
   logic [DW-1:0]   if_rdata;
   logic            dm_req;
   logic            dm_we;
   logic [AW-1:0]   dm_addr;
   logic [DW-1:0]   dm_wdata;
   logic [DW/8-1:0] dm_be;
   logic            dm_gnt;
   logic            dm_rvalid;
   logic [DW-1:0]   dm_rdata;
   logic            m_req;
   logic            m_we;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wdata;
   logic [DW/8-1:0] m_be;
   logic            m_ack;
   logic            m_rvalid;
   logic [DW-1:0]   m_rdata;
   logic            busy;

   int cmpCount = 0;
   int errCount = 0;

   logic [31:0] ifQ[$];
   logic [31:0] dmQ[$];
   logic [31:0] expIf = '0;
   logic [31:0] expDm = '0;

   r200_mem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
      .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .busy(busy)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the directed sequence ever stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmpCount++;
      assert (obs === exp) else begin
         errCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      cmpCount++;
      assert (obs === exp) else begin
         errCount++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One full transaction from grant to response, acting as both requester and memory
   task automatic applyStimulus(input bit isDm, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input int ackDelay, input logic [31:0] rdata,
                                input bit killInWait, input bit keepReq);
      bit expectResp;
      expectResp = !(killInWait && !isDm);
      if (isDm) begin
         dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata; dm_be = be;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      @(negedge clk);
      checkBit(isDm ? "dm_gnt" : "if_gnt", isDm ? dm_gnt : if_gnt, 1'b1);
      checkBit("other_gnt", isDm ? if_gnt : dm_gnt, 1'b0);
      cyc();
      if (!keepReq) begin
         if (isDm) dm_req = 1'b0;
         else      if_req = 1'b0;
      end
      for (int i = 0; i <= ackDelay; i++) begin
         m_ack = (i == ackDelay);
         @(negedge clk);
         checkBit("m_req_issue", m_req, 1'b1);
         checkOutput("m_addr", m_addr, addr);
         checkBit("m_we", m_we, isDm ? we : 1'b0);
         checkBit("gnt_in_issue", if_gnt | dm_gnt, 1'b0);
         if (isDm) begin
            checkOutput("m_be", 32'(m_be), 32'(be));
            if (we) checkOutput("m_wdata", m_wdata, wdata);
         end
         cyc();
      end
      m_ack = 1'b0;
      if (killInWait) if_kill = 1'b1;
      m_rvalid = 1'b1;
      m_rdata  = rdata;
      if (expectResp) begin
         if (isDm) begin
            if (!we) expDm = rdata;
            dmQ.push_back(expDm);
         end else begin
            expIf = rdata;
            ifQ.push_back(expIf);
         end
      end
      @(negedge clk);
      checkBit("busy_wait", busy, 1'b1);
      checkBit("m_req_wait", m_req, 1'b0);
      cyc();
      if_kill  = 1'b0;
      m_rvalid = 1'b0;
      @(negedge clk);
      checkBit("if_rvalid_resp", if_rvalid, !isDm && expectResp);
      checkBit("dm_rvalid_resp", dm_rvalid, isDm);
      checkOutput("if_rdata_resp", if_rdata, expIf);
      checkOutput("dm_rdata_resp", dm_rdata, expDm);
      cyc();
   endtask

   // Scoreboard: every rvalid pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (if_rvalid) begin
         if (ifQ.size() == 0) begin
            cmpCount++;
            errCount++;
            $error("[TB] FAIL if_rvalid_unexpected: observed pulse expected none");
         end else begin
            checkOutput("sb_if_rdata", if_rdata, ifQ.pop_front());
         end
      end
      if (dm_rvalid) begin
         if (dmQ.size() == 0) begin
            cmpCount++;
            errCount++;
            $error("[TB] FAIL dm_rvalid_unexpected: observed pulse expected none");
         end else begin
            checkOutput("sb_dm_rdata", dm_rdata, dmQ.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b0; if_req = 1'b0; if_addr = '0; if_kill = 1'b0;
      dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
      m_ack = 1'b0; m_rvalid = 1'b0; m_rdata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkBit("rst_busy", busy, 1'b0);
      checkBit("rst_m_req", m_req, 1'b0);
      checkBit("rst_if_rvalid", if_rvalid, 1'b0);
      checkBit("rst_dm_rvalid", dm_rvalid, 1'b0);
      checkOutput("rst_m_addr", m_addr, 32'h0);
      checkOutput("rst_if_rdata", if_rdata, 32'h0);
      cyc();
      rst = 1'b1;
      cyc();

      // Test 1: reset while waiting for read data abandons the fetch
      $display("[TB] reset mid-WAIT");
      if_req = 1'b1; if_addr = 32'h40;
      @(negedge clk);
      checkBit("t1_if_gnt", if_gnt, 1'b1);
      cyc();
      if_req = 1'b0; m_ack = 1'b1;
      cyc();
      m_ack = 1'b0;
      @(negedge clk);
      checkBit("t1_busy_wait", busy, 1'b1);
      rst = 1'b0;
      #1;
      checkBit("t1_busy_rst", busy, 1'b0);
      checkBit("t1_m_req_rst", m_req, 1'b0);
      cyc();
      rst = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h00000BAD;
      @(negedge clk);
      checkBit("t1_busy_idle", busy, 1'b0);
      cyc();
      m_rvalid = 1'b0;
      @(negedge clk);
      checkBit("t1_if_rvalid", if_rvalid, 1'b0);
      checkBit("t1_busy_after", busy, 1'b0);
      checkOutput("t1_if_rdata", if_rdata, 32'h0);
      cyc();

      // Test 2: minimum-latency fetch
      $display("[TB] basic fetch");
      applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 32'h00500093, 1'b0, 1'b0);

      // Test 3: simultaneous requests, data first then fetch
      $display("[TB] DM priority");
      if_req = 1'b1; if_addr = 32'h104;
      applyStimulus(1'b1, 1'b0, 32'h2000, 32'h0, 4'hF, 0, 32'h12345678, 1'b0, 1'b0);
      checkOutput("t3_starve_after_dm", 32'(dut.starve_cnt_q), 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, 0, 32'h00A00113, 1'b0, 1'b0);
      checkOutput("t3_starve_after_if", 32'(dut.starve_cnt_q), 32'd0);

      // Test 4: starvation limit forces a fetch grant after four data grants
      $display("[TB] starvation limit");
      if_req = 1'b1; if_addr = 32'h300;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 1'b0, 32'h3000 + 32'(k * 4), 32'h0, 4'hF, 0, 32'hA0000000 + 32'(k), 1'b0, 1'b1);
      end
      checkOutput("t4_starve_sat", 32'(dut.starve_cnt_q), 32'd4);
      applyStimulus(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 0, 32'h00000013, 1'b0, 1'b0);
      dm_req = 1'b0;
      checkOutput("t4_starve_clr", 32'(dut.starve_cnt_q), 32'd0);

      // Test 5: redirect during WAIT drops the fetch, the next one returns normally
      $display("[TB] fetch kill");
      applyStimulus(1'b0, 1'b0, 32'h400, 32'h0, 4'h0, 1, 32'hFFFFFFFF, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h800, 32'h0, 4'h0, 0, 32'h00C00193, 1'b0, 1'b0);

      // Test 6: delayed-ack write keeps the memory request stable
      $display("[TB] delayed write");
      applyStimulus(1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'b0011, 3, 32'h55555555, 1'b0, 1'b0);

      repeat (2) cyc();
      checkOutput("if_queue_empty", 32'(ifQ.size()), 32'd0);
      checkOutput("dm_queue_empty", 32'(dmQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
